// File: rtl/chip8_timer_bank_if.sv
// Register/read bus between the CHIP-8 CPU (master) and the timer bank (slave).
// Carries pause, the single write port, the read mux and the status outputs.
interface chip8_timer_bank_if #(
  parameter int NUM_TIMERS = 2,
  parameter int WIDTH      = 8
);
  localparam int SEL_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;

  logic                        pause;
  logic                        wr_en;
  logic [SEL_W-1:0]            wr_sel;
  logic [WIDTH-1:0]            wr_data;
  logic [SEL_W-1:0]            rd_sel;
  logic [WIDTH-1:0]            rd_data;
  logic [NUM_TIMERS*WIDTH-1:0] timers;
  logic [NUM_TIMERS-1:0]       active;
  logic                        tick;
  logic [NUM_TIMERS-1:0]       expired;

  modport master (
    output pause, wr_en, wr_sel, wr_data, rd_sel,
    input  rd_data, timers, active, tick, expired
  );

  modport slave (
    input  pause, wr_en, wr_sel, wr_data, rd_sel,
    output rd_data, timers, active, tick, expired
  );
endinterface

// File: rtl/chip8_timer_bank.sv
// Bank of NUM_TIMERS saturating down-counters (T0 = delay, T1 = sound) stepped by a TICK_HZ prescaler.
// Optional expiry pulses are generated only when the TIMER_IRQ_EN macro is defined.
module chip8_timer_bank #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 60,
  parameter int NUM_TIMERS = 2,
  parameter int WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  chip8_timer_bank_if.slave    bus
);
  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SEL_W = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  // Timers stop at zero instead of wrapping to all-ones.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? v : v - WIDTH'(1);
  endfunction

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  tick_now;
  logic                  tick_q;
  logic [WIDTH-1:0]      tmr_q [NUM_TIMERS];
  logic [WIDTH-1:0]      tmr_d [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] wr_hit;
  logic [WIDTH-1:0]      rd_mux;
  logic [NUM_TIMERS*WIDTH-1:0] timers_flat;
  logic [NUM_TIMERS-1:0] active_vec;

  assign tick_now = (cnt_q == CNT_MAX) && !bus.pause;

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.pause) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // A write to a timer wins over its decrement on the same edge.
  always_comb begin
    for (int i = 0; i < NUM_TIMERS; i++) begin
      wr_hit[i] = bus.wr_en && (bus.wr_sel == SEL_W'(i));
      if (wr_hit[i]) begin
        tmr_d[i] = bus.wr_data;
      end else if (tick_now) begin
        tmr_d[i] = sat_dec(tmr_q[i]);
      end else begin
        tmr_d[i] = tmr_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        tmr_q[i] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_now;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  // Out-of-range read selects fall through every comparison and read as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (bus.rd_sel == SEL_W'(i)) begin
        rd_mux = tmr_q[i];
      end
    end
  end

  always_comb begin
    timers_flat = '0;
    active_vec  = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      timers_flat[i*WIDTH +: WIDTH] = tmr_q[i];
      active_vec[i]                 = (tmr_q[i] != '0);
    end
  end

  assign bus.rd_data = rd_mux;
  assign bus.timers  = timers_flat;
  assign bus.active  = active_vec;
  assign bus.tick    = tick_q;

`ifdef TIMER_IRQ_EN
  logic [NUM_TIMERS-1:0] exp_q, exp_d;

  // Only a tick-driven 1 -> 0 transition counts; a write on that edge suppresses it.
  always_comb begin
    for (int i = 0; i < NUM_TIMERS; i++) begin
      exp_d[i] = tick_now && !wr_hit[i] && (tmr_q[i] == WIDTH'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign bus.expired = exp_q;
`else
  assign bus.expired = '0;
`endif

endmodule
